deser_field: RTL and testbench
==============================

DESER_FIELD -- requirements
Module: deser_field

Interface
REQ-001 SHALL have parameter WR_WAIT_CYCLES, default 20, meaning idle cycles after each DRAM write before the next state.
REQ-002 SHALL have ports (clock and reset first):
  clk  in  1  single clock, all state on rising edge
  reset  in  1  synchronous, active-high
  en  in  1  start request
  rd_addr  in  64  first byte of the serialized field in the input buffer
  buf_end  in  64  one past the last valid input byte
  obj_addr  in  64  destination slot in the in-memory object
  entry  in  TABLE_ENTRY  expected field_id, field_type, nested
  entry_valid  in  1  entry qualifier
  dram_data_in  in  [7:0][7:0]  read data, lane i = byte at dram_addr[i]
  dram_valid  in  [7:0]  per-lane read-data valid
  ready  out  1  idle, can accept a start
  done  out  1  one-cycle completion pulse
  error  out  1  one-cycle failure pulse
  err_code  out  3  failure cause, held until next start
  rd_ptr_out  out  64  address after the consumed field, valid with done
  dram_en  out  [7:0]  per-lane enable
  dram_rdwr  out  1  1 = read, 0 = write
  dram_addr  out  [7:0][63:0]  per-lane byte address
  dram_data_out  out  [7:0][7:0]  write data

Function
REQ-003 SHALL latch entry, rd_addr, buf_end and obj_addr on start: ready & en & entry_valid & entry.field_id!=0 & ~entry.nested; ready drops next cycle. Other requests are ignored.
REQ-004 SHALL use states IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, DECODE, WR_VAL, WR_LEN, WR_WAIT, DONE, ERROR.
REQ-005 SHALL fetch a 16-byte window: RD_LO drives dram_en=8'hFF, rdwr=1, addr[i]=rd_addr+i for exactly one cycle. WAIT_LO waits for dram_valid==8'hFF. RD_HI/WAIT_HI repeat this with rd_addr+8+i.
REQ-006 DECODE SHALL decode the tag varint at window byte 0: field number = tag>>3, wire type = tag[2:0]. The value SHALL start right after the tag.
REQ-007 Expected wire type SHALL be:
  0 for types 3,4,5,8,13,14,17,18
  1 for 1,6,16
  5 for 2,7,15
  2 for 9,12
REQ-008 Errors SHALL take the first matching check, in this order:
  1 = field number != entry.field_id
  2 = wire type != expected
  3 = varint >10 bytes (tag >5 bytes)
  4 = consumed end > buf_end
  5 = unsupported type
REQ-009 Varint value SHALL be the 7-bit groups, little-endian, with bit 7 as continuation. Types 17/18 SHALL be zigzag-decoded: (v>>1) ^ -(v&1). Types 5/17 SHALL be truncated to 32 bits.
REQ-010 WR_VAL SHALL write little-endian with rdwr=0, addr[i]=obj_addr+i, for one cycle. Lane mask SHALL be 8'h01 for bool, 8'h0F for 32-bit types, 8'hFF otherwise.
REQ-011 For wire type 2, WR_VAL SHALL write the payload address (8 bytes). WR_LEN SHALL then write the length (8 bytes) at obj_addr+8. rd_ptr_out SHALL be the payload address + length.
REQ-012 WR_WAIT SHALL count WR_WAIT_CYCLES after each write, then go to WR_LEN or DONE.
REQ-013 DONE SHALL pulse done for one cycle, set rd_ptr_out and return to IDLE. ERROR SHALL pulse error, set err_code, perform no write, and return to IDLE.
REQ-014 dram_en SHALL be 0 in every state except RD_LO, RD_HI, WR_VAL and WR_LEN.

Reset
REQ-015 Reset SHALL set: state IDLE, ready 1, done 0, error 0, err_code 0, dram_en 0, dram_rdwr 1, dram_addr 0, dram_data_out 0, rd_ptr_out 0, counter 0.
REQ-016 Reset mid-operation SHALL abandon the field with no further DRAM access, and ready SHALL be 1 the next cycle.

Structure
REQ-017 TABLE_ENTRY, the field_type constants, the wire-type enum and the err_code values SHALL live in the shared package.
REQ-018 Varint decoding SHALL be a combinational sub-module varint_decoder: 10-byte input -> 64-bit value, 4-bit length, overlong flag. It is instantiated twice, for tag and value.

Verification
REQ-019 Bytes 08 96 01 at 0x100, buf_end 0x110, entry {id 1, type 5}, obj 0x400 -> 4-byte write 96 00 00 00 at 0x400, done, rd_ptr_out 0x103.
REQ-020 Bytes 10 03, entry {id 2, type 18} -> 8-byte write FFFFFFFFFFFFFFFE, rd_ptr_out = rd_addr+2.
REQ-021 Bytes 1A 05 at 0x200, entry {id 3, type 9}, obj 0x500 -> writes 0x202 at 0x500 and 5 at 0x508, rd_ptr_out 0x207.
REQ-022 Bytes 10 01, entry {id 1, type 5} -> error, err_code 1, no dram write. Bytes 08 FF×10 01 -> err_code 3.
REQ-023 Reset asserted during WAIT_HI -> dram_en 0, ready 1 next cycle. A following start decodes correctly.

Source files
------------

// File: rtl/deser_field_pkg.sv
// deser_field_pkg: shared types, field-type codes, wire types and error codes for the field deserializer.
package deser_field_pkg;

   localparam int VARINT_MAX_BYTES = 10;

   localparam logic [4:0] FT_DOUBLE   = 5'd1;
   localparam logic [4:0] FT_FLOAT    = 5'd2;
   localparam logic [4:0] FT_INT64    = 5'd3;
   localparam logic [4:0] FT_UINT64   = 5'd4;
   localparam logic [4:0] FT_INT32    = 5'd5;
   localparam logic [4:0] FT_FIXED64  = 5'd6;
   localparam logic [4:0] FT_FIXED32  = 5'd7;
   localparam logic [4:0] FT_BOOL     = 5'd8;
   localparam logic [4:0] FT_STRING   = 5'd9;
   localparam logic [4:0] FT_BYTES    = 5'd12;
   localparam logic [4:0] FT_UINT32   = 5'd13;
   localparam logic [4:0] FT_ENUM     = 5'd14;
   localparam logic [4:0] FT_SFIXED32 = 5'd15;
   localparam logic [4:0] FT_SFIXED64 = 5'd16;
   localparam logic [4:0] FT_SINT32   = 5'd17;
   localparam logic [4:0] FT_SINT64   = 5'd18;

   typedef struct packed {
      logic [31:0] field_id;
      logic [4:0]  field_type;
      logic        nested;
   } table_entry_t;

   typedef enum logic [2:0] {
      WT_VARINT = 3'd0,
      WT_I64    = 3'd1,
      WT_LEN    = 3'd2,
      WT_I32    = 3'd5
   } wire_t;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_FIELD    = 3'd1,
      ERR_WIRE     = 3'd2,
      ERR_OVERLONG = 3'd3,
      ERR_BOUNDS   = 3'd4,
      ERR_TYPE     = 3'd5
   } err_t;

   typedef enum logic [3:0] {
      IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, DECODE, WR_VAL, WR_LEN, WR_WAIT, DONE, ERROR
   } state_t;

   function automatic logic supported(input logic [4:0] t);
      return (t >= 5'd1 && t <= 5'd9) || (t >= 5'd12 && t <= 5'd18);
   endfunction

   function automatic wire_t expected_wire(input logic [4:0] t);
      return t inside {FT_DOUBLE, FT_FIXED64, FT_SFIXED64} ? WT_I64 :
             t inside {FT_FLOAT, FT_FIXED32, FT_SFIXED32}  ? WT_I32 :
             t inside {FT_STRING, FT_BYTES}                ? WT_LEN : WT_VARINT;
   endfunction

   function automatic logic [7:0] lane_mask(input logic [4:0] t);
      return t == FT_BOOL ? 8'h01 :
             t inside {FT_FLOAT, FT_INT32, FT_FIXED32, FT_UINT32, FT_ENUM, FT_SFIXED32, FT_SINT32} ? 8'h0F : 8'hFF;
   endfunction

endpackage

// File: rtl/deser_field_varint_decoder.sv
// varint_decoder: combinational little-endian base-128 varint decode over a 10-byte window.
module varint_decoder
   import deser_field_pkg::*;
(
   input  logic [8*VARINT_MAX_BYTES-1:0] din,
   output logic [63:0]                   value,
   output logic [3:0]                    len,
   output logic                          overlong
);

   always_comb begin
      value = '0;
      len = 4'(VARINT_MAX_BYTES);
      overlong = 1'b1;
      for (int i = 0; i < VARINT_MAX_BYTES; i++)
         if (overlong) begin
            value = value | (64'(din[8*i +: 7]) << (7*i));
            if (!din[8*i+7]) begin
               overlong = 1'b0;
               len = 4'(i + 1);
            end
         end
   end

endmodule

// File: rtl/deser_field.sv
// deser_field: fetches a 16-byte window, decodes one tagged field and writes it into the object slot.
module deser_field
   import deser_field_pkg::*;
#(
   parameter int WR_WAIT_CYCLES = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [63:0]      rd_addr,
   input  logic [63:0]      buf_end,
   input  logic [63:0]      obj_addr,
   input  table_entry_t     entry,
   input  logic             entry_valid,
   input  logic [7:0][7:0]  dram_data_in,
   input  logic [7:0]       dram_valid,
   output logic             ready,
   output logic             done,
   output logic             error,
   output logic [2:0]       err_code,
   output logic [63:0]      rd_ptr_out,
   output logic [7:0]       dram_en,
   output logic             dram_rdwr,
   output logic [7:0][63:0] dram_addr,
   output logic [7:0][7:0]  dram_data_out
);

   state_t state, state_n;
   logic [127:0] win;
   logic [63:0] ra_q, be_q, oa_q, val_q, len_q, end_q;
   logic [31:0] id_q, cnt;
   logic [4:0] ty_q;
   logic [7:0] mask_q;
   logic is_len_q, phase_q, start, wait_over;
   logic [63:0] tag_v, val_v, vaddr, fixed, vint_z, vint, dec_data, dec_end, base;
   logic [3:0] tag_len, val_len, val_start;
   logic tag_ovl, val_ovl, overlong;
   logic [2:0] wt, dec_err;

   assign start = ready & en & entry_valid & (entry.field_id != '0) & ~entry.nested;
   assign wait_over = cnt + 32'd1 >= 32'(WR_WAIT_CYCLES);

   varint_decoder u_tag (.din(win[79:0]), .value(tag_v), .len(tag_len), .overlong(tag_ovl));
   varint_decoder u_val (.din(80'(win >> (8*val_start))), .value(val_v), .len(val_len), .overlong(val_ovl));

   // the value decoder window is clamped so an overlong tag cannot push it past the 16 fetched bytes
   always_comb begin
      wt = tag_v[2:0];
      val_start = tag_len > 4'd5 ? 4'd5 : tag_len;
      vaddr = ra_q + 64'(val_start);
      fixed = 64'(win >> (8*val_start));
      vint_z = (ty_q == FT_SINT32 || ty_q == FT_SINT64) ? (val_v >> 1) ^ {64{val_v[0]}} : val_v;
      vint = (ty_q == FT_INT32 || ty_q == FT_SINT32) ? {32'd0, vint_z[31:0]} : vint_z;
      dec_data = wt == WT_LEN ? vaddr + 64'(val_len) :
                 wt == WT_I64 ? fixed :
                 wt == WT_I32 ? {32'd0, fixed[31:0]} : vint;
      dec_end = wt == WT_VARINT ? vaddr + 64'(val_len) :
                wt == WT_I64    ? vaddr + 64'd8 :
                wt == WT_I32    ? vaddr + 64'd4 :
                wt == WT_LEN    ? vaddr + 64'(val_len) + val_v : vaddr;
      overlong = tag_ovl || tag_len > 4'd5 || ((wt == WT_VARINT || wt == WT_LEN) && val_ovl);
      dec_err = (tag_v >> 3) != 64'(id_q)                   ? ERR_FIELD :
                supported(ty_q) && wt != expected_wire(ty_q) ? ERR_WIRE :
                overlong                                     ? ERR_OVERLONG :
                dec_end > be_q                               ? ERR_BOUNDS :
                !supported(ty_q)                             ? ERR_TYPE : ERR_NONE;
   end

   always_comb begin
      state_n = state;
      ready = state == IDLE;
      done = state == DONE;
      error = state == ERROR;
      dram_en = '0;
      dram_rdwr = 1'b1;
      dram_addr = '0;
      dram_data_out = '0;
      base = state == RD_HI ? ra_q + 64'd8 : state == WR_VAL ? oa_q : state == WR_LEN ? oa_q + 64'd8 : ra_q;
      case (state)
         IDLE:    state_n = start ? RD_LO : IDLE;
         RD_LO:   begin state_n = WAIT_LO; dram_en = 8'hFF; end
         WAIT_LO: state_n = dram_valid == 8'hFF ? RD_HI : WAIT_LO;
         RD_HI:   begin state_n = WAIT_HI; dram_en = 8'hFF; end
         WAIT_HI: state_n = dram_valid == 8'hFF ? DECODE : WAIT_HI;
         DECODE:  state_n = dec_err != ERR_NONE ? ERROR : WR_VAL;
         WR_VAL:  begin state_n = WR_WAIT; dram_en = mask_q; dram_rdwr = 1'b0; dram_data_out = val_q; end
         WR_LEN:  begin state_n = WR_WAIT; dram_en = 8'hFF; dram_rdwr = 1'b0; dram_data_out = len_q; end
         WR_WAIT: state_n = !wait_over ? WR_WAIT : (is_len_q && !phase_q) ? WR_LEN : DONE;
         default: state_n = IDLE;
      endcase
      if (dram_en != '0)
         for (int i = 0; i < 8; i++) dram_addr[i] = base + 64'(i);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         err_code <= '0;
         rd_ptr_out <= '0;
         cnt <= '0;
         win <= '0;
         {ra_q, be_q, oa_q, val_q, len_q, end_q} <= '0;
         {id_q, ty_q, mask_q, is_len_q, phase_q} <= '0;
      end else begin
         state <= state_n;
         cnt <= (state == WR_WAIT && state_n == WR_WAIT) ? cnt + 32'd1 : '0;
         if (start) begin
            ra_q <= rd_addr;
            be_q <= buf_end;
            oa_q <= obj_addr;
            id_q <= entry.field_id;
            ty_q <= entry.field_type;
            err_code <= '0;
            phase_q <= 1'b0;
         end
         if (state == WAIT_LO && dram_valid == 8'hFF) win[63:0] <= dram_data_in;
         if (state == WAIT_HI && dram_valid == 8'hFF) win[127:64] <= dram_data_in;
         if (state == DECODE) begin
            val_q <= dec_data;
            len_q <= val_v;
            end_q <= dec_end;
            mask_q <= lane_mask(ty_q);
            is_len_q <= wt == WT_LEN;
            err_code <= dec_err;
         end
         if (state == WR_LEN) phase_q <= 1'b1;
         if (state_n == DONE) rd_ptr_out <= end_q;
      end
   end

endmodule

// File: tb/tb_deser_field.sv
// tb_deser_field: directed field decodes against a byte-memory DRAM model, checked through an event scoreboard.
module tb_deser_field;
   import deser_field_pkg::*;

   localparam int WT = 5;
   localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;

   logic clk = 1'b0;
   logic reset = 1'b1, en = 1'b0, entry_valid = 1'b0;
   logic [63:0] rd_addr = '0, buf_end = '0, obj_addr = '0;
   table_entry_t entry = '0;
   logic [7:0][7:0] dram_data_in = '0;
   logic [7:0] dram_valid = '0;
   logic ready, done, error, dram_rdwr;
   logic [2:0] err_code;
   logic [63:0] rd_ptr_out;
   logic [7:0] dram_en;
   logic [7:0][63:0] dram_addr;
   logic [7:0][7:0] dram_data_out;

   typedef struct {
      int          kind;
      logic [63:0] addr;
      logic [7:0]  mask;
      logic [63:0] data;
      bit          gap;
   } ev_t;

   ev_t sb[$];
   int checks = 0, failures = 0;
   longint cyc = 0, last_wr = 0;
   logic [7:0] mem [0:4095];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   deser_field #(.WR_WAIT_CYCLES(WT)) dut (
      .clk(clk), .reset(reset), .en(en), .rd_addr(rd_addr), .buf_end(buf_end), .obj_addr(obj_addr),
      .entry(entry), .entry_valid(entry_valid), .dram_data_in(dram_data_in), .dram_valid(dram_valid),
      .ready(ready), .done(done), .error(error), .err_code(err_code), .rd_ptr_out(rd_ptr_out),
      .dram_en(dram_en), .dram_rdwr(dram_rdwr), .dram_addr(dram_addr), .dram_data_out(dram_data_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int a, input logic [127:0] b, input int n);
      for (int k = 0; k < n; k++) mem[a+k] = b[8*k +: 8];
   endtask

   task automatic expect_wr(input logic [63:0] a, input logic [7:0] m, input logic [63:0] d, input bit g);
      sb.push_back('{K_WR, a, m, d, g});
   endtask

   task automatic expect_done(input logic [63:0] p);
      sb.push_back('{K_DONE, 64'd0, 8'd0, p, 1'b1});
   endtask

   task automatic expect_err(input logic [63:0] c);
      sb.push_back('{K_ERR, 64'd0, 8'd0, c, 1'b0});
   endtask

   task automatic start_field(input logic [63:0] ra, input logic [63:0] be, input logic [63:0] oa,
                              input logic [31:0] id, input logic [4:0] ty, input logic nst);
      @(negedge clk);
      rd_addr = ra; buf_end = be; obj_addr = oa;
      entry = '{field_id: id, field_type: ty, nested: nst};
      entry_valid = 1'b1; en = 1'b1;
      @(negedge clk);
      en = 1'b0; entry_valid = 1'b0;
   endtask

   task automatic run(input logic [63:0] ra, input logic [63:0] be, input logic [63:0] oa,
                      input logic [31:0] id, input logic [4:0] ty);
      start_field(ra, be, oa, id, ty, 1'b0);
      check("ready_drop", ready, 0);
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      check("ready_idle", ready, 1);
   endtask

   // DRAM read responder: full-width valid two cycles after each read request
   initial begin
      int pend;
      logic [7:0][63:0] a;
      pend = 0;
      a = '0;
      forever begin
         @(negedge clk);
         if (pend == 1) begin
            for (int i = 0; i < 8; i++) dram_data_in[i] = mem[a[i][11:0]];
            dram_valid = 8'hFF;
         end else dram_valid = '0;
         if (pend > 0) pend--;
         if (dram_en == 8'hFF && dram_rdwr) begin
            pend = 2;
            a = dram_addr;
         end
      end
   end

   initial begin
      ev_t e;
      logic [63:0] m;
      forever begin
         @(negedge clk);
         if (!reset && dram_en != '0 && !dram_rdwr) begin
            check("wr_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{e.mask[i]}};
               check("wr_kind", K_WR, e.kind);
               check("wr_mask", dram_en, e.mask);
               check("wr_addr0", dram_addr[0], e.addr);
               check("wr_addr7", dram_addr[7], e.addr + 64'd7);
               check("wr_data", dram_data_out & m, e.data & m);
               if (e.gap) check("wr_gap", cyc - last_wr, WT + 1);
            end
            last_wr = cyc;
         end
         if (done) begin
            check("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("done_kind", K_DONE, e.kind);
               check("rd_ptr_out", rd_ptr_out, e.data);
               check("done_gap", cyc - last_wr, WT + 1);
            end
         end
         if (error) begin
            check("error_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("error_kind", K_ERR, e.kind);
               check("err_code", err_code, e.data);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_code", err_code, 0);
      check("rst_dram_en", dram_en, 0);
      check("rst_rdwr", dram_rdwr, 1);
      check("rst_rd_ptr", rd_ptr_out, 0);
      check("rst_addr", dram_addr != '0, 0);
      check("rst_wdata", dram_data_out, 0);
      reset = 1'b0;

      load(12'h100, 128'h01_96_08, 3);
      expect_wr(64'h400, 8'h0F, 64'h96, 1'b0);
      expect_done(64'h103);
      run(64'h100, 64'h110, 64'h400, 1, FT_INT32);

      load(12'h180, 128'h03_10, 2);
      expect_wr(64'h410, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      expect_done(64'h182);
      run(64'h180, 64'h190, 64'h410, 2, FT_SINT64);

      load(12'h200, 128'h6F_6C_6C_65_68_05_1A, 7);
      expect_wr(64'h500, 8'hFF, 64'h202, 1'b0);
      expect_wr(64'h508, 8'hFF, 64'h5, 1'b1);
      expect_done(64'h207);
      run(64'h200, 64'h210, 64'h500, 3, FT_STRING);

      load(12'h240, 128'h01_10, 2);
      expect_err(1);
      run(64'h240, 64'h250, 64'h450, 1, FT_INT32);
      check("err_hold", err_code, 1);

      load(12'h280, 128'h01_FFFFFFFFFFFFFFFFFFFF_08, 12);
      expect_err(3);
      run(64'h280, 64'h2A0, 64'h460, 1, FT_INT32);

      load(12'h2A0, 128'h05_08, 2);
      expect_err(2);
      run(64'h2A0, 64'h2B0, 64'h460, 1, FT_STRING);
      expect_err(5);
      run(64'h2A0, 64'h2B0, 64'h460, 1, 5'd10);

      load(12'h2C0, 128'h01_96_08, 3);
      expect_err(4);
      run(64'h2C0, 64'h2C2, 64'h470, 1, FT_INT32);
      expect_wr(64'h470, 8'h0F, 64'h96, 1'b0);
      expect_done(64'h2C3);
      run(64'h2C0, 64'h2C3, 64'h470, 1, FT_INT32);
      check("err_cleared", err_code, 0);

      load(12'h300, 128'h01_40, 2);
      expect_wr(64'h480, 8'h01, 64'h1, 1'b0);
      expect_done(64'h302);
      run(64'h300, 64'h310, 64'h480, 8, FT_BOOL);

      load(12'h340, 128'h12_34_56_78_25, 5);
      expect_wr(64'h490, 8'h0F, 64'h1234_5678, 1'b0);
      expect_done(64'h345);
      run(64'h340, 64'h350, 64'h490, 4, FT_FIXED32);

      start_field(64'h100, 64'h110, 64'h400, 1, FT_INT32, 1'b1);
      check("nested_ignored", ready, 1);
      start_field(64'h100, 64'h110, 64'h400, 0, FT_INT32, 1'b0);
      check("id0_ignored", ready, 1);
      repeat (3) @(negedge clk);
      check("ignored_no_dram", dram_en, 0);

      start_field(64'h100, 64'h110, 64'h600, 1, FT_INT32, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (dram_en == 8'hFF && dram_rdwr && dram_addr[0] == 64'h108) found = 1'b1;
         else @(negedge clk);
      end
      check("rd_hi_seen", found, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_dram_en", dram_en, 0);
      check("abort_ready", ready, 1);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_quiet", dram_en, 0);
      end

      expect_wr(64'h610, 8'h0F, 64'h96, 1'b0);
      expect_done(64'h103);
      run(64'h100, 64'h110, 64'h610, 1, FT_INT32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
